uart_tx_fifo: RTL and testbench

- Buffered transmit front-end for uart_top.
- Producers push bytes with a one-cycle write strobe, without watching the UART busy flag. The block queues up to DEPTH bytes.
- A drain FSM feeds uart_top one byte at a time through its i_wr / i_data / o_busy handshake.
- Placement: between message sources (ROM printer, command echo) and uart_top's transmit side.

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 tb/tb_uart_tx_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: drain FSM states and ASCII line-ending bytes.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head, registered status flags
// and a one-cycle overflow pulse for pushes dropped while full.
module sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count,
  output logic                  o_overflow
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
  logic          push, pop;

  always_comb begin
    push       = i_wr_en && !full_q;
    pop        = i_pop && !empty_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    // A drop is judged on the full flag alone, so a same-cycle pop does not rescue it.
    overflow_d = i_wr_en && full_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_head     = mem_q[rd_ptr_q];
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: queues bytes and drains them one per frame into uart_top.
// Optional UART_TX_FIFO_CRLF_EN expands each LF head byte into CR then LF.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_uart_wr,
  output logic [DATA_WIDTH-1:0]    o_uart_data,
  input  logic                     i_uart_busy
);
  localparam int TW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  tx_state_e             state_q, state_d;
  logic                  ready_q, ready_d, wr_q, wr_d, issue, pop;
  logic [DATA_WIDTH-1:0] data_q, data_d, head;
  logic [TW-1:0]         timer_q, timer_d;
`ifdef UART_TX_FIFO_CRLF_EN
  logic                  cr_sent_q, cr_sent_d;
`endif

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_pop      (pop),
    .o_head     (head),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    timer_d = timer_q;
    pop     = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_d = cr_sent_q;
`endif
    // ready_q confirms the FIFO/busy view held for a full cycle before we strobe.
    issue = (state_q == IDLE) && ready_q && !o_empty && !i_uart_busy;
    case (state_q)
      IDLE: if (issue) begin
        wr_d    = 1'b1;
        timer_d = '0;
        state_d = WAIT_BUSY;
`ifdef UART_TX_FIFO_CRLF_EN
        if (head == DATA_WIDTH'(ASCII_LF) && !cr_sent_q) begin
          data_d    = DATA_WIDTH'(ASCII_CR);
          cr_sent_d = 1'b1;
        end else begin
          data_d    = head;
          pop       = 1'b1;
          cr_sent_d = 1'b0;
        end
`else
        data_d = head;
        pop    = 1'b1;
`endif
      end
      WAIT_BUSY: begin
        if (i_uart_busy)                      state_d = WAIT_DONE;
        else if (timer_q == TW'(BUSY_WAIT-1)) state_d = IDLE;
        else                                  timer_d = timer_q + TW'(1);
      end
      WAIT_DONE: if (!i_uart_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) && !o_empty && !i_uart_busy;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      timer_q <= '0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q <= cr_sent_d;
`endif
    end
  end

  assign o_uart_wr   = wr_q;
  assign o_uart_data = data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_top busy model and strobe recorder.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, uart_wr, busy = 1'b0;
  logic [4:0] count;
  logic [7:0] uart_data;

  int   n_chk = 0, n_pass = 0;
  logic [7:0] rx_q[$];
  time        t_q[$];
  int   busy_len = 0, busy_cnt = 0, max_cnt = 0, ovf_n = 0;
  logic force_busy = 1'b0;
  time  tp;

  uart_tx_fifo #(.DEPTH(16), .DATA_WIDTH(8), .BUSY_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow),
    .o_uart_wr(uart_wr), .o_uart_data(uart_data), .i_uart_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic wait_rx(input int n, input int max_cyc);
    int k = 0;
    while (rx_q.size() < n && k < max_cyc) begin @(negedge clk); k++; end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); wr_en = 1'b1; wr_data = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk); wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // uart_top stand-in: busy rises the cycle after a strobe and lasts busy_len cycles.
  initial forever begin
    @(negedge clk);
    if (force_busy) busy = 1'b1;
    else if (busy_cnt > 0) begin busy_cnt--; busy = (busy_cnt != 0); end
    else if (uart_wr && busy_len > 0) begin busy = 1'b1; busy_cnt = busy_len; end
    else busy = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (uart_wr) begin rx_q.push_back(uart_data); t_q.push_back($time); end
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (overflow) ovf_n++;
  end

  initial begin
    logic [7:0] exp_crlf[$];
    // Reset held for 3 cycles while the write strobe toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_en = ~wr_en; wr_data = 8'h55;
      chk("rst_empty", empty, 1); chk("rst_count", count, 0); chk("rst_wr", uart_wr, 0);
    end
    @(negedge clk); rst = 1'b0; wr_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_no_strobe", rx_q.size(), 0);
    chk("idle_empty", empty, 1);

    // Single byte latency and spacing to the next frame.
    busy_len = 20;
    @(negedge clk); tp = $time; wr_en = 1'b1; wr_data = 8'h41;
    push(8'h42);
    idle(0);
    wait_rx(2, 80);
    if (rx_q.size() >= 2) begin
      chk("first_data", rx_q[0], 8'h41);
      chk("first_latency", 32'(t_q[0] - tp), 30);
      chk("second_data", rx_q[1], 8'h42);
      chk("second_spacing", 32'(t_q[1] - t_q[0]), 220);
    end
    repeat (40) @(negedge clk);
    chk("single_pulse_total", rx_q.size(), 2);
    rx_q.delete(); t_q.delete();

    // Fill to full with the UART busy, then overflow one byte.
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    ovf_n = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin chk("full", full, 1); chk("count16", count, 16); chk("no_ovf_yet", overflow, 0); end
      wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    chk("ovf_pulse", overflow, 1); chk("count_hold", count, 16);
    @(negedge clk);
    chk("ovf_one_cycle", overflow, 0);
    chk("no_strobe_busy", rx_q.size(), 0);
    busy_len = 3; force_busy = 1'b0;
    wait_rx(16, 600);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("fill_order", rx_q[i], 32'(i));
    repeat (20) @(negedge clk);
    chk("fill_total", rx_q.size(), 16);
    chk("fill_drained", empty, 1);
    rx_q.delete(); t_q.delete();

    // Streaming with wrap against a 10-cycle frame.
    busy_len = 10; max_cnt = 0; ovf_n = 0;
    for (int i = 0; i < 40; i++) begin push(8'((i * 7 + 3) & 8'hFF)); idle(7); end
    wait_rx(40, 1500);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) chk("stream_data", rx_q[i], 32'((i * 7 + 3) & 8'hFF));
    chk("stream_max_le16", 32'(max_cnt <= 16), 1);
    chk("stream_no_ovf", ovf_n, 0);
    repeat (30) @(negedge clk);
    rx_q.delete(); t_q.delete();

    // Busy never rises: strobes advance on the timeout alone.
    busy_len = 0;
    @(negedge clk); tp = $time; wr_en = 1'b1; wr_data = 8'h11;
    push(8'h22); push(8'h33); idle(0);
    wait_rx(3, 100);
    if (rx_q.size() >= 3) begin
      chk("to_data0", rx_q[0], 8'h11); chk("to_data1", rx_q[1], 8'h22); chk("to_data2", rx_q[2], 8'h33);
      chk("to_latency", 32'(t_q[0] - tp), 30);
      chk("to_space1", 32'(t_q[1] - t_q[0]), 50);
      chk("to_space2", 32'(t_q[2] - t_q[1]), 50);
    end
    repeat (20) @(negedge clk);
    chk("to_total", rx_q.size(), 3); chk("to_empty", empty, 1);
    rx_q.delete(); t_q.delete();

    // Reset with queued data discards it.
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    push(8'hA1); push(8'hA2); push(8'hA3); idle(0);
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_count", count, 0); chk("mid_rst_empty", empty, 1);
    rst = 1'b0; force_busy = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_no_tx", rx_q.size(), 0);
    rx_q.delete(); t_q.delete();

    // Line feed handling.
    busy_len = 3;
`ifdef UART_TX_FIFO_CRLF_EN
    exp_crlf = '{8'h48, 8'h0D, 8'h0A};
`else
    exp_crlf = '{8'h48, 8'h0A};
`endif
    push(8'h48); push(8'h0A); idle(0);
    wait_rx(exp_crlf.size(), 200);
    for (int i = 0; i < exp_crlf.size() && i < rx_q.size(); i++) chk("crlf_data", rx_q[i], exp_crlf[i]);
    repeat (30) @(negedge clk);
    chk("crlf_total", rx_q.size(), exp_crlf.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
